switch_out_sched: RTL and testbench
===================================

SWITCH_OUT_SCHED -- requirements
Module: switch_out_sched

Interface
REQ-001 Parameter DEPTH, default 8, output FIFO depth in packets; power of two, at least 2.
REQ-002 Parameter NREQ, default 4, number of requesting input ports; fixed at 4 in this revision.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 req_valid  input  NREQ  per-requester packet-valid for this output port.
REQ-006 req_pkt  input  NREQ*16  per-requester packet, slice i = bits [16i+15:16i], layout {source[3:0], target[3:0], data[7:0]}.
REQ-007 req_ready  output  NREQ  per-requester grant; one-hot or zero.
REQ-008 out_valid  output  1  head packet available.
REQ-009 out_pkt  output  16  head packet, same layout as req_pkt slice.
REQ-010 out_ready  input  1  downstream accepts head packet.
REQ-011 fifo_count  output  $clog2(DEPTH)+1  packets currently stored.

Function
REQ-012 A requester transfers a packet in a cycle with req_valid[i] and req_ready[i] both high; the push is exactly one packet per cycle.
REQ-013 req_ready is combinational from req_valid, rr_ptr and fifo_count; req_valid shall not depend on req_ready.
REQ-014 No grant is issued when fifo_count == DEPTH, even if a pop occurs in the same cycle.
REQ-015 When not full, req_ready[i] is high for the first i with req_valid[i] high, searching rr_ptr, rr_ptr+1, ... modulo NREQ; all other bits are low.
REQ-016 rr_ptr is a log2(NREQ)-bit register; after a grant to i it becomes (i+1) mod NREQ; with no grant it holds its value.
REQ-017 A pushed packet is written at wr_ptr; wr_ptr increments modulo DEPTH.
REQ-018 out_valid = (fifo_count != 0), and out_pkt = entry at rd_ptr; both are driven from registers with no bypass, giving 1-cycle push-to-out_valid latency when empty.
REQ-019 A pop occurs when out_valid and out_ready are both high; rd_ptr then increments modulo DEPTH.
REQ-020 out_ready while empty is ignored, with no pointer or count change.
REQ-021 Simultaneous push and pop leave fifo_count unchanged; push only adds 1, and pop only subtracts 1.
REQ-022 out_pkt and out_valid are held stable while out_valid is high and out_ready is low.
REQ-023 Packets leave in exact push order; none are dropped or duplicated.
REQ-024 A requester not granted keeps its packet; fairness is bounded: a continuously-valid requester is granted within NREQ grants.

Reset
REQ-025 rst_n low asynchronously clears rr_ptr, wr_ptr, rd_ptr and fifo_count to 0.
REQ-026 While rst_n is low, out_valid = 0 and req_ready = 0; out_pkt is don't-care.
REQ-027 Reset mid-operation discards all stored packets; FIFO storage needs no reset.
REQ-028 The first grant after reset release goes to the lowest-index valid requester.

Structure
REQ-029 Package switch_pkg holds pkt_t (packed source[3:0], target[3:0], data[7:0]), NUM_PORTS = 4 and OUT_FIFO_DEPTH = 8.
REQ-030 The ring buffer is one sub-module, switch_sync_fifo (parameter DEPTH, push/pop/full/empty/count).
REQ-031 Round-robin grant logic lives in switch_out_sched itself.
REQ-032 switch_out_sched is instantiated once per output port by the switch top.

Verification
REQ-033 Contention test: all four req_valid are held high with distinct data 0x10..0x13, out_ready = 1, from reset -> grants in order 0,1,2,3,0,... and out_pkt data follows the same order, each 1 cycle after its push.
REQ-034 Full test: out_ready = 0 and req_valid[2] = 1 for 10 cycles -> 8 grants, fifo_count = 8, then req_ready = 0; raising out_ready drains 8 packets in order.
REQ-035 Full-plus-pop test: FIFO full, out_ready = 1 and req_valid[1] = 1 -> no grant that cycle, fifo_count = 7 next cycle, then grant resumes.
REQ-036 Push-and-pop test: one packet stored, simultaneous push and pop -> fifo_count stays 1 and the next out_pkt is the pushed packet.
REQ-037 Reset test: rst_n is pulsed low mid-stream with 5 packets stored -> out_valid = 0 immediately, fifo_count = 0, first post-reset grant goes to the lowest valid index.
REQ-038 Wrap test: 20 packets are streamed through a single requester with random out_ready -> scoreboard shows in-order delivery across pointer wrap-around with no loss.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared types and constants for the switch output-port datapath.
// Latency: none (declarations only).
// Backpressure: n/a.
package switch_pkg;

  localparam int NUM_PORTS      = 4;
  localparam int OUT_FIFO_DEPTH = 8;
  localparam int PKT_W          = 16;

  // Packet as carried on every requester lane and on the output.
  typedef struct packed {
    logic [3:0] source;
    logic [3:0] target;
    logic [7:0] data;
  } pkt_t;

endpackage

// File: rtl/switch_out_sched_if.sv
// Bundles the requester lanes and the output stream of one output-port scheduler.
// Latency: none (wiring only).
// Backpressure: req_ready grants a requester; out_ready stalls the output head.
// Ports:
//   req_valid/req_pkt/req_ready : NREQ packed requester lanes, 16 bits per lane
//   out_valid/out_pkt/out_ready : output stream (head of the output FIFO)
//   fifo_count                  : packets currently buffered
// master = upstream/downstream environment, slave = the scheduler.
interface switch_out_sched_if #(
  parameter int NREQ  = 4,
  parameter int DEPTH = 8
);
  import switch_pkg::*;

  logic [NREQ-1:0]         req_valid;
  logic [NREQ*PKT_W-1:0]   req_pkt;
  logic [NREQ-1:0]         req_ready;
  logic                    out_valid;
  pkt_t                    out_pkt;
  logic                    out_ready;
  logic [$clog2(DEPTH):0]  fifo_count;

  modport master (
    output req_valid, req_pkt, out_ready,
    input  req_ready, out_valid, out_pkt, fifo_count
  );

  modport slave (
    input  req_valid, req_pkt, out_ready,
    output req_ready, out_valid, out_pkt, fifo_count
  );

endinterface

// File: rtl/switch_sync_fifo.sv
// Synchronous ring-buffer FIFO of packets.
// Latency: a push is visible at pop_pkt/empty after one clock edge; no write-to-read bypass.
// Backpressure: push is dropped when full and pop is ignored when empty; callers gate on full/empty.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset (pointers/count only)
//   push, push_pkt      : write one packet at the write pointer
//   pop, pop_pkt        : advance past the head packet; pop_pkt is the head
//   full, empty, count  : occupancy status
module switch_sync_fifo
  import switch_pkg::*;
#(
  parameter int DEPTH = OUT_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  pkt_t                    push_pkt,
  input  logic                    pop,
  output pkt_t                    pop_pkt,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);

  pkt_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset: a cleared count already marks every entry stale.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_pkt;
  end

  assign pop_pkt = mem[rd_ptr];
  assign count   = count_q;

endmodule

// File: rtl/switch_out_sched.sv
// Output-port scheduler: round-robin arbitration of NREQ requesters into an output FIFO.
// Latency: one cycle from a granted push to out_valid when the FIFO is empty.
// Backpressure: no grant while the FIFO is full (even with a pop that cycle); out_ready stalls the head.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of switch_out_sched_if (requester lanes, output stream, fifo_count)
module switch_out_sched
  import switch_pkg::*;
#(
  parameter int DEPTH = OUT_FIFO_DEPTH,
  parameter int NREQ  = NUM_PORTS
) (
  input  logic               clk,
  input  logic               rst_n,
  switch_out_sched_if.slave  bus
);

  // NREQ is a power of two (4 in this revision), so pointer overflow wraps modulo NREQ.
  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   idx;
  logic [PW-1:0]   grant_idx;
  logic            grant_any;
  logic [NREQ-1:0] grant;
  pkt_t            push_pkt;
  pkt_t            head_pkt;
  logic            full;
  logic            empty;
  logic            pop;
  logic [$clog2(DEPTH):0] count;

  // Search starting at rr_ptr; the first valid lane found wins.
  // Gating on full (not full-after-pop) keeps req_ready off the out_ready path.
  // Gating on rst_n keeps every grant low while reset is held.
  always_comb begin
    idx       = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = rr_ptr + PW'(k);
      if (!grant_any && bus.req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
    if (full || !rst_n) begin
      grant_any = 1'b0;
    end
    grant = grant_any ? (NREQ'(1) << grant_idx) : '0;
  end

  // The pointer moves just past the winner so it ranks last next time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= grant_idx + PW'(1);
    end
  end

  // Lane select: each lane is PKT_W (16) bits, so the lane offset is grant_idx * 16.
  assign push_pkt = pkt_t'(bus.req_pkt[{grant_idx, 4'b0000} +: PKT_W]);
  assign pop      = bus.out_ready && !empty;

  switch_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (grant_any),
    .push_pkt (push_pkt),
    .pop      (pop),
    .pop_pkt  (head_pkt),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  assign bus.req_ready  = grant;
  assign bus.out_valid  = !empty;
  assign bus.out_pkt    = head_pkt;
  assign bus.fifo_count = count;

endmodule

// File: tb/tb_switch_out_sched.sv
// Directed bench for switch_out_sched: contention, full, full+pop, push+pop, mid-stream reset, wrap.
// Inputs change on the falling edge; outputs are sampled 1 ns later, away from the rising edge.
module tb_switch_out_sched;
  import switch_pkg::*;

  localparam int DEPTH = 8;
  localparam int NREQ  = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;

  switch_out_sched_if #(.NREQ(NREQ), .DEPTH(DEPTH)) bus ();

  switch_out_sched #(.DEPTH(DEPTH), .NREQ(NREQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mk(input logic [3:0] s, input logic [3:0] t, input logic [7:0] d);
    return {s, t, d};
  endfunction

  task automatic set_pkt(input int i, input logic [15:0] p);
    bus.req_pkt[i*16 +: 16] = p;
  endtask

  task automatic test_reset;
    bus.req_valid = 4'hF;
    bus.req_pkt   = '0;
    bus.out_ready = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk); #1;
    if (bus.req_ready !== 4'b0) begin miscompares++; $display("FAIL reset_req_ready got=%b exp=0000", bus.req_ready); end
    vectors++;
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    vectors++;
    if (bus.fifo_count !== CW'(0)) begin miscompares++; $display("FAIL reset_fifo_count got=%0d exp=0", bus.fifo_count); end
    vectors++;
    bus.req_valid = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // All four lanes valid from reset: grants rotate 0,1,2,3,... and each packet appears one cycle later.
  task automatic test_contention;
    logic [3:0]  exp_rdy;
    logic [15:0] exp_pkt;
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) set_pkt(i, mk(4'(i), 4'h5, 8'(8'h10 + i)));
    bus.req_valid = 4'hF;
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      exp_rdy = 4'b0001 << (c % 4);
      if (bus.req_ready !== exp_rdy) begin miscompares++; $display("FAIL contention_grant c=%0d got=%b exp=%b", c, bus.req_ready, exp_rdy); end
      vectors++;
      if (bus.out_valid !== (c != 0)) begin miscompares++; $display("FAIL contention_valid c=%0d got=%b exp=%b", c, bus.out_valid, (c != 0)); end
      vectors++;
      if (c > 0) begin
        exp_pkt = mk(4'((c - 1) % 4), 4'h5, 8'(8'h10 + (c - 1) % 4));
        if (bus.out_pkt !== exp_pkt) begin miscompares++; $display("FAIL contention_pkt c=%0d got=%h exp=%h", c, bus.out_pkt, exp_pkt); end
        vectors++;
        if (bus.fifo_count !== CW'(1)) begin miscompares++; $display("FAIL contention_count c=%0d got=%0d exp=1", c, bus.fifo_count); end
        vectors++;
      end
      @(negedge clk);
    end
    bus.req_valid = 4'h0;
    @(negedge clk); #1;
    if (bus.fifo_count !== CW'(0)) begin miscompares++; $display("FAIL contention_drain got=%0d exp=0", bus.fifo_count); end
    vectors++;
  endtask

  // Lane 2 alone with output stalled: 8 grants then none; then drain in order.
  task automatic test_full;
    int exp_cnt;
    logic [3:0]  exp_rdy;
    logic [15:0] exp_pkt;
    @(negedge clk);
    bus.out_ready = 1'b0;
    exp_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      bus.req_valid = 4'b0100;
      set_pkt(2, mk(4'h2, 4'h1, 8'(8'h20 + exp_cnt)));
      #1;
      exp_rdy = (exp_cnt < DEPTH) ? 4'b0100 : 4'b0000;
      if (bus.req_ready !== exp_rdy) begin miscompares++; $display("FAIL full_grant c=%0d got=%b exp=%b", c, bus.req_ready, exp_rdy); end
      vectors++;
      if (bus.fifo_count !== CW'(exp_cnt)) begin miscompares++; $display("FAIL full_count c=%0d got=%0d exp=%0d", c, bus.fifo_count, exp_cnt); end
      vectors++;
      if (exp_cnt < DEPTH) exp_cnt++;
      @(negedge clk);
    end
    #1;
    if (bus.fifo_count !== CW'(8)) begin miscompares++; $display("FAIL full_count_final got=%0d exp=8", bus.fifo_count); end
    vectors++;
    bus.req_valid = 4'h0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      exp_pkt = mk(4'h2, 4'h1, 8'(8'h20 + k));
      if (bus.out_valid !== 1'b1 || bus.out_pkt !== exp_pkt) begin
        miscompares++; $display("FAIL full_drain k=%0d got=%b/%h exp=1/%h", k, bus.out_valid, bus.out_pkt, exp_pkt);
      end
      vectors++;
      @(negedge clk);
    end
    #1;
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL full_empty_valid got=%b exp=0", bus.out_valid); end
    vectors++;
    bus.out_ready = 1'b0;
  endtask

  // Full FIFO with a pop in the same cycle still refuses the grant; the grant returns a cycle later.
  task automatic test_full_plus_pop;
    logic [15:0] exp_pkt;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b0010;
    for (int k = 0; k < 8; k++) begin
      set_pkt(1, mk(4'h1, 4'h3, 8'(8'h30 + k)));
      #1;
      if (bus.req_ready !== 4'b0010) begin miscompares++; $display("FAIL fpp_fill k=%0d got=%b exp=0010", k, bus.req_ready); end
      vectors++;
      @(negedge clk);
    end
    set_pkt(1, mk(4'h1, 4'h3, 8'h38));
    bus.out_ready = 1'b1;
    #1;
    if (bus.req_ready !== 4'b0000) begin miscompares++; $display("FAIL fpp_no_grant got=%b exp=0000", bus.req_ready); end
    vectors++;
    if (bus.fifo_count !== CW'(8)) begin miscompares++; $display("FAIL fpp_count8 got=%0d exp=8", bus.fifo_count); end
    vectors++;
    @(negedge clk); #1;
    if (bus.fifo_count !== CW'(7)) begin miscompares++; $display("FAIL fpp_count7 got=%0d exp=7", bus.fifo_count); end
    vectors++;
    if (bus.req_ready !== 4'b0010) begin miscompares++; $display("FAIL fpp_resume got=%b exp=0010", bus.req_ready); end
    vectors++;
    @(negedge clk);
    bus.req_valid = 4'h0;
    for (int k = 2; k <= 8; k++) begin
      #1;
      exp_pkt = mk(4'h1, 4'h3, 8'(8'h30 + k));
      if (bus.out_pkt !== exp_pkt) begin miscompares++; $display("FAIL fpp_drain k=%0d got=%h exp=%h", k, bus.out_pkt, exp_pkt); end
      vectors++;
      @(negedge clk);
    end
    #1;
    if (bus.fifo_count !== CW'(0)) begin miscompares++; $display("FAIL fpp_empty got=%0d exp=0", bus.fifo_count); end
    vectors++;
    bus.out_ready = 1'b0;
  endtask

  // One packet stored, push and pop together: count stays 1, new head is the pushed packet.
  task automatic test_push_pop;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b0001;
    set_pkt(0, mk(4'h0, 4'h7, 8'h40));
    @(negedge clk);
    set_pkt(0, mk(4'h0, 4'h7, 8'h41));
    bus.out_ready = 1'b1;
    #1;
    if (bus.fifo_count !== CW'(1) || bus.out_pkt !== mk(4'h0, 4'h7, 8'h40)) begin
      miscompares++; $display("FAIL pp_before got=%0d/%h exp=1/0740", bus.fifo_count, bus.out_pkt);
    end
    vectors++;
    if (bus.req_ready !== 4'b0001) begin miscompares++; $display("FAIL pp_grant got=%b exp=0001", bus.req_ready); end
    vectors++;
    @(negedge clk);
    bus.req_valid = 4'h0;
    #1;
    if (bus.fifo_count !== CW'(1)) begin miscompares++; $display("FAIL pp_count got=%0d exp=1", bus.fifo_count); end
    vectors++;
    if (bus.out_pkt !== mk(4'h0, 4'h7, 8'h41)) begin miscompares++; $display("FAIL pp_head got=%h exp=0741", bus.out_pkt); end
    vectors++;
    @(negedge clk); #1;
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL pp_empty got=%b exp=0", bus.out_valid); end
    vectors++;
    bus.out_ready = 1'b0;
  endtask

  // Five packets stored and rr_ptr left at 2; reset clears everything, first grant goes to lane 1.
  task automatic test_reset_mid;
    @(negedge clk);
    bus.out_ready = 1'b0;
    set_pkt(1, mk(4'h1, 4'h0, 8'h64));
    for (int k = 0; k < 5; k++) begin
      bus.req_valid = (k < 4) ? 4'b1000 : 4'b0010;
      set_pkt(3, mk(4'h3, 4'h0, 8'(8'h60 + k)));
      @(negedge clk);
    end
    #1;
    if (bus.fifo_count !== CW'(5)) begin miscompares++; $display("FAIL rmid_stored got=%0d exp=5", bus.fifo_count); end
    vectors++;
    bus.req_valid = 4'b1110;
    for (int i = 1; i < 4; i++) set_pkt(i, mk(4'(i), 4'h0, 8'(8'h70 + i)));
    #1 rst_n = 1'b0;
    #1;
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_valid got=%b exp=0", bus.out_valid); end
    vectors++;
    if (bus.fifo_count !== CW'(0)) begin miscompares++; $display("FAIL rmid_count got=%0d exp=0", bus.fifo_count); end
    vectors++;
    if (bus.req_ready !== 4'b0000) begin miscompares++; $display("FAIL rmid_ready got=%b exp=0000", bus.req_ready); end
    vectors++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    if (bus.req_ready !== 4'b0010) begin miscompares++; $display("FAIL rmid_first_grant got=%b exp=0010", bus.req_ready); end
    vectors++;
    @(negedge clk);
    bus.req_valid = 4'h0;
    #1;
    if (bus.fifo_count !== CW'(1) || bus.out_pkt !== mk(4'h1, 4'h0, 8'h71)) begin
      miscompares++; $display("FAIL rmid_first_pkt got=%0d/%h exp=1/1071", bus.fifo_count, bus.out_pkt);
    end
    vectors++;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  // 20 packets through lane 0 with random out_ready, checked against a queue scoreboard.
  task automatic test_wrap;
    logic [15:0] q[$];
    logic [15:0] cur;
    logic [3:0]  exp_rdy;
    int sent;
    int rcvd;
    sent = 0;
    rcvd = 0;
    @(negedge clk);
    for (int cyc = 0; cyc < 400 && rcvd < 20; cyc++) begin
      cur = mk(4'h0, 4'h2, 8'(8'h80 + sent));
      bus.req_valid = (sent < 20) ? 4'b0001 : 4'b0000;
      set_pkt(0, cur);
      bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      if (bus.fifo_count !== CW'(q.size())) begin miscompares++; $display("FAIL wrap_count cyc=%0d got=%0d exp=%0d", cyc, bus.fifo_count, q.size()); end
      vectors++;
      if (bus.out_valid !== (q.size() != 0)) begin miscompares++; $display("FAIL wrap_valid cyc=%0d got=%b exp=%b", cyc, bus.out_valid, (q.size() != 0)); end
      vectors++;
      exp_rdy = (sent < 20 && q.size() < DEPTH) ? 4'b0001 : 4'b0000;
      if (bus.req_ready !== exp_rdy) begin miscompares++; $display("FAIL wrap_grant cyc=%0d got=%b exp=%b", cyc, bus.req_ready, exp_rdy); end
      vectors++;
      if (q.size() != 0 && bus.out_ready) begin
        if (bus.out_pkt !== q[0]) begin miscompares++; $display("FAIL wrap_pkt cyc=%0d got=%h exp=%h", cyc, bus.out_pkt, q[0]); end
        vectors++;
        void'(q.pop_front());
        rcvd++;
      end
      if (exp_rdy[0]) begin
        q.push_back(cur);
        sent++;
      end
      @(negedge clk);
    end
    if (rcvd != 20) begin miscompares++; $display("FAIL wrap_delivered got=%0d exp=20", rcvd); end
    vectors++;
    bus.req_valid = 4'h0;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_pkt   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_contention();
    test_full();
    test_full_plus_pop();
    test_push_pop();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
